// File: rtl/s298_bist_pkg.sv
// Shared types, polynomials and next-state helpers for the s298 BIST driver.
package s298_bist_pkg;

    localparam int SIG_W  = 16;
    localparam int RESP_W = 6;

    localparam logic [SIG_W-1:0] LFSR_POLY     = 16'hB400;
    localparam logic [SIG_W-1:0] MISR_POLY     = 16'h1021;
    localparam logic [SIG_W-1:0] SEED_ZERO_SUB = 16'h0001;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CLEAR   = 3'd1,
        RUN     = 3'd2,
        DRAIN   = 3'd3,
        DONE_ST = 3'd4
    } state_t;

    // Galois right-shift LFSR step
    function automatic logic [SIG_W-1:0] lfsr_next(input logic [SIG_W-1:0] v);
        return {1'b0, v[SIG_W-1:1]} ^ (v[0] ? LFSR_POLY : '0);
    endfunction

    // Left-shift MISR step; responses fold into the low bits
    function automatic logic [SIG_W-1:0] misr_next(input logic [SIG_W-1:0] v,
                                                   input logic [RESP_W-1:0] resp);
        return {v[SIG_W-2:0], 1'b0} ^ (v[SIG_W-1] ? MISR_POLY : '0)
               ^ {{(SIG_W-RESP_W){1'b0}}, resp};
    endfunction

endpackage

// File: rtl/s298_misr.sv
// Multiple-input signature register compacting the six s298 responses.
module s298_misr
    import s298_bist_pkg::*;
(
    input  logic              CK,
    input  logic              RST,
    input  logic              clr,
    input  logic              en,
    input  logic [RESP_W-1:0] resp,
    output logic [SIG_W-1:0]  sig
);

    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            sig <= '0;
        end else if (clr) begin
            sig <= '0;
        end else if (en) begin
            sig <= misr_next(sig, resp);
        end
    end

endmodule

// File: rtl/s298_bist_driver.sv
// BIST driver for one s298: LFSR stimulus, MISR response compaction and
// START/DONE handshake with a pass/fail signature compare.
module s298_bist_driver
    import s298_bist_pkg::*;
#(
    parameter int unsigned N_PATTERNS = 1024,
    parameter int unsigned CLR_CYCLES = 2
) (
    input  logic              CK,
    input  logic              RST,
    input  logic              START,
    input  logic [SIG_W-1:0]  SEED,
    input  logic [SIG_W-1:0]  EXP_SIG,
    output logic              G0,
    output logic              G1,
    output logic              G2,
    input  logic              G66,
    input  logic              G67,
    input  logic              G117,
    input  logic              G118,
    input  logic              G132,
    input  logic              G133,
    output logic              BUSY,
    output logic              DONE,
    output logic              PASS,
    output logic [SIG_W-1:0]  SIGNATURE
);

    localparam logic [15:0] CLR_LAST = 16'(CLR_CYCLES - 1);
    localparam logic [15:0] PAT_LAST = 16'(N_PATTERNS - 1);

    state_t             state;
    state_t             state_nxt;
    logic [SIG_W-1:0]   lfsr;
    logic [15:0]        clr_cnt;
    logic [15:0]        pat_cnt;
    logic               cap_en;
    logic [SIG_W-1:0]   exp_sig;
    logic               pass_q;
    logic               accept;
    logic               sig_match;
    logic [RESP_W-1:0]  resp;

    assign accept    = START && (state == IDLE);
    assign resp      = {G133, G132, G118, G117, G67, G66};
    assign sig_match = (SIGNATURE == exp_sig);

    // The final MISR capture lands on the DRAIN->DONE_ST edge, so the compare
    // is only meaningful from DONE_ST onwards; it is then frozen in pass_q.
    assign PASS = (state == DONE_ST) ? sig_match : pass_q;

    always_comb begin
        state_nxt = state;
        G0        = 1'b0;
        G1        = 1'b0;
        G2        = 1'b0;
        BUSY      = 1'b0;
        DONE      = 1'b0;
        case (state)
            IDLE: begin
                if (START) state_nxt = CLEAR;
            end
            CLEAR: begin
                G0   = 1'b1;
                BUSY = 1'b1;
                if (clr_cnt == CLR_LAST) state_nxt = RUN;
            end
            RUN: begin
                G1   = lfsr[0];
                G2   = lfsr[1];
                G0   = &lfsr[4:2];
                BUSY = 1'b1;
                if (pat_cnt == PAT_LAST) state_nxt = DRAIN;
            end
            DRAIN: begin
                BUSY      = 1'b1;
                state_nxt = DONE_ST;
            end
            DONE_ST: begin
                DONE      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            state   <= IDLE;
            lfsr    <= SEED_ZERO_SUB;
            clr_cnt <= '0;
            pat_cnt <= '0;
            cap_en  <= 1'b0;
            exp_sig <= '0;
            pass_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            // s298 answers one edge after the stimulus, so capture trails RUN by one cycle
            cap_en <= (state == RUN);

            if (accept) begin
                lfsr    <= (SEED == '0) ? SEED_ZERO_SUB : SEED;
                exp_sig <= EXP_SIG;
                pass_q  <= 1'b0;
            end else if (state == RUN) begin
                lfsr <= lfsr_next(lfsr);
            end

            clr_cnt <= ((state == CLEAR) && (clr_cnt != CLR_LAST)) ? clr_cnt + 16'd1 : '0;
            pat_cnt <= ((state == RUN) && (pat_cnt != PAT_LAST)) ? pat_cnt + 16'd1 : '0;

            if (state == DONE_ST) pass_q <= sig_match;
        end
    end

    s298_misr u_misr (
        .CK   (CK),
        .RST  (RST),
        .clr  (accept),
        .en   (cap_en),
        .resp (resp),
        .sig  (SIGNATURE)
    );

endmodule

// File: tb/tb_s298_bist_driver.sv
// Self-checking bench: three driver instances (1, 2 and 1024 patterns), the
// largest closed around a small behavioural s298 stand-in.
module tb_s298_bist_driver;

    typedef struct {
        logic [15:0] sig;
        logic        pass;
        int          lat;
    } exp_t;

    logic        CK = 1'b0;
    logic        RST;
    logic [2:0]  start_a;
    logic [15:0] seed_a [3];
    logic [15:0] exp_a  [3];
    logic [2:0]  g0_a, g1_a, g2_a, busy_a, done_a, pass_a;
    logic [15:0] sig_a  [3];
    logic [5:0]  resp0, resp1, resp2;
    logic [5:0]  m_s;

    int checks = 0;
    int errors = 0;
    exp_t       sb [$];
    logic [2:0] gq [$];

    always #5 CK = ~CK;

    function automatic logic [15:0] g_lfsr(input logic [15:0] v);
        return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    function automatic logic [15:0] g_misr(input logic [15:0] v, input logic [5:0] r);
        return {v[14:0], 1'b0} ^ (v[15] ? 16'h1021 : 16'h0000) ^ {10'd0, r};
    endfunction

    function automatic logic [5:0] m_step(input logic [5:0] s, input logic g1, input logic g2);
        return {s[4:0], s[5] ^ g1} ^ (g2 ? 6'b100101 : 6'b000000);
    endfunction

    function automatic logic [15:0] golden_sig(input logic [15:0] seed, input int n);
        logic [15:0] l, m;
        logic [5:0]  s;
        l = (seed == 16'h0) ? 16'h0001 : seed;
        m = 16'h0;
        s = 6'h0;
        for (int k = 0; k < n; k++) begin
            s = (&l[4:2]) ? 6'h0 : m_step(s, l[0], l[1]);
            m = g_misr(m, s);
            l = g_lfsr(l);
        end
        return m;
    endfunction

    // Behavioural s298 stand-in: registered outputs, G0 is a synchronous clear
    always_ff @(posedge CK) begin
        if (RST || g0_a[2]) m_s <= 6'h0;
        else                m_s <= m_step(m_s, g1_a[2], g2_a[2]);
    end

    assign resp0 = 6'b000000;
    assign resp1 = 6'b000001;
    assign resp2 = m_s;

    s298_bist_driver #(.N_PATTERNS(1), .CLR_CYCLES(2)) u_n1 (
        .CK(CK), .RST(RST), .START(start_a[0]), .SEED(seed_a[0]), .EXP_SIG(exp_a[0]),
        .G0(g0_a[0]), .G1(g1_a[0]), .G2(g2_a[0]),
        .G66(resp0[0]), .G67(resp0[1]), .G117(resp0[2]), .G118(resp0[3]), .G132(resp0[4]), .G133(resp0[5]),
        .BUSY(busy_a[0]), .DONE(done_a[0]), .PASS(pass_a[0]), .SIGNATURE(sig_a[0])
    );

    s298_bist_driver #(.N_PATTERNS(2), .CLR_CYCLES(2)) u_n2 (
        .CK(CK), .RST(RST), .START(start_a[1]), .SEED(seed_a[1]), .EXP_SIG(exp_a[1]),
        .G0(g0_a[1]), .G1(g1_a[1]), .G2(g2_a[1]),
        .G66(resp1[0]), .G67(resp1[1]), .G117(resp1[2]), .G118(resp1[3]), .G132(resp1[4]), .G133(resp1[5]),
        .BUSY(busy_a[1]), .DONE(done_a[1]), .PASS(pass_a[1]), .SIGNATURE(sig_a[1])
    );

    s298_bist_driver #(.N_PATTERNS(1024), .CLR_CYCLES(2)) u_main (
        .CK(CK), .RST(RST), .START(start_a[2]), .SEED(seed_a[2]), .EXP_SIG(exp_a[2]),
        .G0(g0_a[2]), .G1(g1_a[2]), .G2(g2_a[2]),
        .G66(resp2[0]), .G67(resp2[1]), .G117(resp2[2]), .G118(resp2[3]), .G132(resp2[4]), .G133(resp2[5]),
        .BUSY(busy_a[2]), .DONE(done_a[2]), .PASS(pass_a[2]), .SIGNATURE(sig_a[2])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge CK);
    endtask

    task automatic pulse_start(input int i);
        start_a[i] = 1'b1;
        @(negedge CK);
        start_a[i] = 1'b0;
    endtask

    task automatic start_job(input int i, input logic [15:0] seed, input logic [15:0] exp_sig,
                             input logic [15:0] sig, input logic pass, input int lat);
        exp_t e;
        e.sig  = sig;
        e.pass = pass;
        e.lat  = lat;
        sb.push_back(e);
        seed_a[i] = seed;
        exp_a[i]  = exp_sig;
        pulse_start(i);
    endtask

    // lat0 = negedges already elapsed since START was raised
    task automatic finish_job(input int i, input int lat0, input string tag);
        exp_t e;
        int   lat;
        lat = lat0;
        while (done_a[i] !== 1'b1 && lat < 2000) begin
            @(negedge CK);
            lat++;
        end
        e = sb.pop_front();
        chk({tag, "_done_lat"}, 32'(lat), 32'(e.lat));
        chk({tag, "_sig"}, 32'(sig_a[i]), 32'(e.sig));
        chk({tag, "_pass"}, 32'(pass_a[i]), 32'(e.pass));
        chk({tag, "_busy_at_done"}, 32'(busy_a[i]), 32'd0);
        @(negedge CK);
        chk({tag, "_done_1cyc"}, 32'(done_a[i]), 32'd0);
        chk({tag, "_pass_held"}, 32'(pass_a[i]), 32'(e.pass));
        chk({tag, "_sig_held"}, 32'(sig_a[i]), 32'(e.sig));
    endtask

    initial begin
        int          dcount;
        logic [15:0] l;
        logic [15:0] gold;

        RST     = 1'b1;
        start_a = 3'b000;
        for (int i = 0; i < 3; i++) begin
            seed_a[i] = 16'h0;
            exp_a[i]  = 16'h0;
        end
        cyc(2);
        for (int i = 0; i < 3; i++)
            chk("reset_outputs", 32'({g0_a[i], g1_a[i], g2_a[i], busy_a[i], done_a[i], pass_a[i], sig_a[i]}), 32'd0);
        RST = 1'b0;
        cyc(1);

        // CLEAR window and early RUN stimulus, then reset in RUN cycle 5
        seed_a[2] = 16'h0001;
        pulse_start(2);
        chk("clear1_g0_busy", 32'({g0_a[2], g1_a[2], g2_a[2], busy_a[2]}), 32'b1001);
        cyc(1);
        chk("clear2_g0_busy", 32'({g0_a[2], g1_a[2], g2_a[2], busy_a[2]}), 32'b1001);
        l = 16'h0001;
        for (int k = 0; k < 5; k++) begin
            gq.push_back({&l[4:2], l[0], l[1]});
            l = g_lfsr(l);
        end
        cyc(1);
        chk("run1_g_const", 32'({g0_a[2], g1_a[2], g2_a[2]}), 32'b010);
        for (int k = 0; k < 5; k++) begin
            chk("run_g_vs_lfsr", 32'({g0_a[2], g1_a[2], g2_a[2]}), 32'(gq.pop_front()));
            chk("run_busy", 32'(busy_a[2]), 32'd1);
            if (k < 4) cyc(1);
        end
        #2 RST = 1'b1;
        #1 chk("midrun_reset_outputs",
               32'({g0_a[2], g1_a[2], g2_a[2], busy_a[2], done_a[2], pass_a[2], sig_a[2]}), 32'd0);
        @(negedge CK);
        RST = 1'b0;
        dcount = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge CK);
            if (done_a[2] === 1'b1) dcount++;
        end
        chk("no_done_after_reset", 32'(dcount), 32'd0);
        chk("idle_after_reset", 32'(busy_a[2]), 32'd0);

        // One pattern, zero seed replaced by 1, all-zero responses
        start_job(0, 16'h0000, 16'h0000, 16'h0000, 1'b1, 5);
        cyc(2);
        chk("n1_run_g", 32'({g0_a[0], g1_a[0], g2_a[0]}), 32'b010);
        finish_job(0, 3, "n1");

        // Two patterns with G66 tied high
        start_job(1, 16'h5A5A, 16'h0003, 16'h0003, 1'b1, 6);
        finish_job(1, 1, "n2_match");
        start_job(1, 16'h5A5A, 16'h0004, 16'h0003, 1'b0, 6);
        chk("n2_pass_cleared_at_start", 32'(pass_a[1]), 32'd0);
        finish_job(1, 1, "n2_mismatch");

        // Closed loop, full length, with a START pulse ignored mid-run
        gold = golden_sig(16'hACE1, 1024);
        start_job(2, 16'hACE1, gold, gold, 1'b1, 2 + 1024 + 2);
        cyc(100);
        seed_a[2] = 16'h1234;
        pulse_start(2);
        chk("busy_start_ignored", 32'(busy_a[2]), 32'd1);
        finish_job(2, 102, "loop1024");
        dcount = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge CK);
            if (done_a[2] === 1'b1) dcount++;
        end
        chk("loop1024_single_done", 32'(dcount), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
